seg_fun_btn_ctrl: RTL and testbench
===================================

# seg_fun_btn_ctrl

Input stage in front of the seven-segment animation core. It takes the four raw push-button inputs (inc/dec animation, inc/dec speed), synchronises and debounces them, and turns each accepted press into a single-cycle pulse. It also owns the animation-select and speed-level registers that the display core consumes. The core never sees raw button levels.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable synchronised samples needed to accept a press or a release (1 ms at 50 MHz); minimum 1.
- NUM_ANI, 8: number of animations; ani_sel counts 0..NUM_ANI-1; minimum 2.
- SPEED_LEVELS, 8: number of speed levels; speed_lvl counts 0..SPEED_LEVELS-1.
- SPEED_INIT, 3: reset value of speed_lvl; must be < SPEED_LEVELS.

Ports:
- clk  in  1  single system clock
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  design enable; low forces all debouncers idle
- btn  in  4  raw, active-high, asynchronous: [0] inc anim, [1] dec anim, [2] inc speed, [3] dec speed
- btn_pulse  out  4  one-cycle pulse per accepted press, same bit order as btn
- ani_sel  out  $clog2(NUM_ANI)  current animation index
- speed_lvl  out  $clog2(SPEED_LEVELS)  current speed level
- cfg_changed  out  1  one-cycle pulse on any cycle where ani_sel or speed_lvl changes

## Operation

- Each btn bit passes through a 2-FF synchroniser, then into its own debounce FSM with a counter of width $clog2(DEBOUNCE_CYCLES+1).
- FSM states:
  - IDLE → PRESS_WAIT when the sync input is 1; the counter loads 1.
  - PRESS_WAIT: while the input stays 1, the counter increments. A 0 returns the FSM to IDLE with the counter cleared. When the counter reaches DEBOUNCE_CYCLES, the FSM goes to HELD and the btn_pulse bit is 1 in the following cycle.
  - HELD: a 0 moves the FSM to RELEASE_WAIT with the counter loaded to 1. No auto-repeat.
  - RELEASE_WAIT: while the input stays 0, the counter increments. A 1 returns the FSM to HELD without a new pulse. When the counter reaches DEBOUNCE_CYCLES, the FSM goes to IDLE.
- Config update is registered on the same edge that raises btn_pulse:
  - ani_sel: increment wraps NUM_ANI-1→0; decrement wraps 0→NUM_ANI-1.
  - speed_lvl: saturating; increment at SPEED_LEVELS-1 and decrement at 0 produce no change.
- Simultaneous inc and dec pulses on the same pair in one cycle: no change to that register. The two pulses are still emitted.
- Animation and speed pairs update independently in the same cycle.
- cfg_changed is 1 only if a register value actually changes. It is 0 for a saturated speed press or a cancelled inc/dec pair.
- ena = 0: all FSMs are forced to IDLE, counters clear, btn_pulse = 0, and ani_sel and speed_lvl hold. The synchronisers keep sampling.

## Timing

- Reset values: btn_pulse = 0, cfg_changed = 0, ani_sel = 0, speed_lvl = SPEED_INIT, all FSMs in IDLE, synchronisers 0.
- Latency: btn rises and stays high, first sampled at edge k. btn_pulse is high during the cycle after edge k+1+DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 edges after the first sample. The pulse lasts exactly 1 cycle.
- ani_sel, speed_lvl and cfg_changed change on the same edge that raises btn_pulse.
- Shortest accepted press-to-press spacing: 2*DEBOUNCE_CYCLES+2 cycles (press, then full release).
- Reset asserted mid-count or mid-HELD: everything returns immediately to reset values. A button still held after reset release is treated as a new press and produces one pulse after full debounce.
- All outputs are registered; no combinational path exists from btn or ena to any output.

## Structure

- Package seg_fun_pkg holds:
  - button index constants BTN_INC_ANI = 0, BTN_DEC_ANI = 1, BTN_INC_SPD = 2, BTN_DEC_SPD = 3;
  - the debounce state enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT);
  - default NUM_ANI, SPEED_LEVELS and SPEED_INIT constants, shared with the display core.
- Sub-module seg_fun_debounce holds the synchroniser, FSM and counter for one button, with parameter DEBOUNCE_CYCLES. It is instantiated 4 times.
- The top level holds the config registers and the cfg_changed logic.

## Test plan

All scenarios use DEBOUNCE_CYCLES = 4, NUM_ANI = 6, SPEED_LEVELS = 8, SPEED_INIT = 3.

- Reset, then hold btn = 0 for 20 cycles → ani_sel = 0, speed_lvl = 3, no pulses.
- btn[0] high for 20 cycles → exactly one btn_pulse[0], 6 cycles after the first sampling edge; ani_sel = 1 and cfg_changed pulses once. Releasing and pressing btn[0] 5 more times → ani_sel sequence 2, 3, 4, 5, 0.
- btn[1] toggling high 3 cycles / low 1 cycle for 40 cycles → no pulse and ani_sel unchanged. Then high steady → one pulse, ani_sel 0→5.
- 5 clean presses of btn[2] → speed_lvl 4, 5, 6, 7, 7; 5 pulses but only 4 cfg_changed. 8 presses of btn[3] → speed_lvl reaches 0 and stays at 0.
- btn[0] and btn[1] rising on the same edge and held → both pulses in the same cycle, ani_sel unchanged, cfg_changed = 0.
- rst_n low for 1 cycle while btn[2] is in PRESS_WAIT → speed_lvl = 3. btn[2] still held → one pulse 6 cycles after reset release, speed_lvl = 4. Separately, ena low during a press → no pulse and registers held.

Source files
------------

// File: rtl/seg_fun_pkg.sv
// Shared definitions for the button input stage and the seven-segment display core.
package seg_fun_pkg;

    localparam int NUM_BTN     = 4;
    localparam int BTN_INC_ANI = 0;
    localparam int BTN_DEC_ANI = 1;
    localparam int BTN_INC_SPD = 2;
    localparam int BTN_DEC_SPD = 3;

    localparam int DEF_NUM_ANI      = 8;
    localparam int DEF_SPEED_LEVELS = 8;
    localparam int DEF_SPEED_INIT   = 3;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_e;

endpackage

// File: rtl/seg_fun_debounce.sv
// One button: 2-FF synchroniser, press/release debounce FSM, single-cycle press pulse.
module seg_fun_debounce
    import seg_fun_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic btn_raw,
    output logic press_accept,
    output logic pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync1_reg;
    logic             sync2_reg;
    deb_state_e       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             pulse_reg;

    // Lets the parent update its config on the very edge that raises the pulse.
    assign press_accept = ena && (state_reg == PRESS_WAIT) && sync2_reg && (cnt_reg == CNT_MAX);
    assign pulse        = pulse_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= btn_raw;
            sync2_reg <= sync1_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            pulse_reg <= 1'b0;
        end else begin
            pulse_reg <= 1'b0;
            if (!ena) begin
                state_reg <= IDLE;
                cnt_reg   <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (sync2_reg) begin
                            state_reg <= PRESS_WAIT;
                            cnt_reg   <= CNT_ONE;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!sync2_reg) begin
                            state_reg <= IDLE;
                            cnt_reg   <= '0;
                        end else if (cnt_reg == CNT_MAX) begin
                            state_reg <= HELD;
                            cnt_reg   <= '0;
                            pulse_reg <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_ONE;
                        end
                    end
                    HELD: begin
                        if (!sync2_reg) begin
                            state_reg <= RELEASE_WAIT;
                            cnt_reg   <= CNT_ONE;
                        end
                    end
                    RELEASE_WAIT: begin
                        // A bounce back to 1 resumes the held state without a second pulse.
                        if (sync2_reg) begin
                            state_reg <= HELD;
                            cnt_reg   <= '0;
                        end else if (cnt_reg == CNT_MAX) begin
                            state_reg <= IDLE;
                            cnt_reg   <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_ONE;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/seg_fun_btn_ctrl.sv
// Button input stage: four debouncers plus the animation-select and speed-level registers.
module seg_fun_btn_ctrl
    import seg_fun_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int NUM_ANI         = DEF_NUM_ANI,
    parameter int SPEED_LEVELS    = DEF_SPEED_LEVELS,
    parameter int SPEED_INIT      = DEF_SPEED_INIT
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            ena,
    input  logic [NUM_BTN-1:0]              btn,
    output logic [NUM_BTN-1:0]              btn_pulse,
    output logic [$clog2(NUM_ANI)-1:0]      ani_sel,
    output logic [$clog2(SPEED_LEVELS)-1:0] speed_lvl,
    output logic                            cfg_changed
);

    localparam int ANI_W = $clog2(NUM_ANI);
    localparam int SPD_W = $clog2(SPEED_LEVELS);
    localparam logic [ANI_W-1:0] ANI_MAX = ANI_W'(NUM_ANI - 1);
    localparam logic [ANI_W-1:0] ANI_ONE = ANI_W'(1);
    localparam logic [SPD_W-1:0] SPD_MAX = SPD_W'(SPEED_LEVELS - 1);
    localparam logic [SPD_W-1:0] SPD_ONE = SPD_W'(1);
    localparam logic [SPD_W-1:0] SPD_RST = SPD_W'(SPEED_INIT);

    logic [NUM_BTN-1:0] accept;
    logic [ANI_W-1:0]   ani_reg, ani_next;
    logic [SPD_W-1:0]   spd_reg, spd_next;
    logic               cfg_changed_reg;

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_deb
            seg_fun_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clk          (clk),
                .rst_n        (rst_n),
                .ena          (ena),
                .btn_raw      (btn[gi]),
                .press_accept (accept[gi]),
                .pulse        (btn_pulse[gi])
            );
        end
    endgenerate

    // Opposing presses in the same cycle cancel; each pair is evaluated independently.
    always_comb begin
        ani_next = ani_reg;
        if (accept[BTN_INC_ANI] && !accept[BTN_DEC_ANI]) begin
            ani_next = (ani_reg == ANI_MAX) ? '0 : ani_reg + ANI_ONE;
        end else if (accept[BTN_DEC_ANI] && !accept[BTN_INC_ANI]) begin
            ani_next = (ani_reg == '0) ? ANI_MAX : ani_reg - ANI_ONE;
        end

        spd_next = spd_reg;
        if (accept[BTN_INC_SPD] && !accept[BTN_DEC_SPD]) begin
            if (spd_reg != SPD_MAX) spd_next = spd_reg + SPD_ONE;
        end else if (accept[BTN_DEC_SPD] && !accept[BTN_INC_SPD]) begin
            if (spd_reg != '0) spd_next = spd_reg - SPD_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ani_reg         <= '0;
            spd_reg         <= SPD_RST;
            cfg_changed_reg <= 1'b0;
        end else begin
            ani_reg         <= ani_next;
            spd_reg         <= spd_next;
            cfg_changed_reg <= (ani_next != ani_reg) || (spd_next != spd_reg);
        end
    end

    assign ani_sel     = ani_reg;
    assign speed_lvl   = spd_reg;
    assign cfg_changed = cfg_changed_reg;

endmodule

// File: tb/tb_seg_fun_btn_ctrl.sv
// Directed bench for seg_fun_btn_ctrl with a run-length behavioural model checked every cycle.
module tb_seg_fun_btn_ctrl;

    localparam int D  = 4;
    localparam int NA = 6;
    localparam int SL = 8;
    localparam int SI = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [3:0] btn;
    logic [3:0] btn_pulse;
    logic [2:0] ani_sel;
    logic [2:0] speed_lvl;
    logic       cfg_changed;

    int errors = 0;
    int checks = 0;
    int edge_cnt = 0;
    int pcnt[4] = '{0, 0, 0, 0};
    int last_edge[4] = '{0, 0, 0, 0};
    int cfg_cnt = 0;

    // Model state: synchroniser delay line, accepted level and length of the disagreeing run.
    bit m_p1[4], m_p2[4], m_lvl[4];
    int m_run[4];
    bit m_pulse[4];
    int m_ani, m_spd;
    bit m_cfg;

    seg_fun_btn_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .NUM_ANI        (NA),
        .SPEED_LEVELS   (SL),
        .SPEED_INIT     (SI)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .btn         (btn),
        .btn_pulse   (btn_pulse),
        .ani_sel     (ani_sel),
        .speed_lvl   (speed_lvl),
        .cfg_changed (cfg_changed)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: run did not finish within bound");
        $fatal(1, "timeout");
    end

    // Model step and per-cycle comparison, 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            edge_cnt++;
            if (!rst_n) begin
                for (int b = 0; b < 4; b++) begin
                    m_p1[b] = 0; m_p2[b] = 0; m_lvl[b] = 0; m_run[b] = 0; m_pulse[b] = 0;
                end
                m_ani = 0;
                m_spd = SI;
                m_cfg = 0;
            end else begin
                int na, ns;
                bit ai, ad, si, sd;
                for (int b = 0; b < 4; b++) begin
                    bit s;
                    s = m_p2[b];
                    m_pulse[b] = 0;
                    if (!ena) begin
                        m_lvl[b] = 0;
                        m_run[b] = 0;
                    end else if (s != m_lvl[b]) begin
                        m_run[b]++;
                        if (m_run[b] == D + 1) begin
                            m_lvl[b] = s;
                            m_run[b] = 0;
                            if (s) m_pulse[b] = 1;
                        end
                    end else begin
                        m_run[b] = 0;
                    end
                    m_p2[b] = m_p1[b];
                    m_p1[b] = btn[b];
                end
                ai = m_pulse[0] && !m_pulse[1];
                ad = m_pulse[1] && !m_pulse[0];
                si = m_pulse[2] && !m_pulse[3];
                sd = m_pulse[3] && !m_pulse[2];
                na = ai ? (m_ani + 1) % NA : ad ? (m_ani + NA - 1) % NA : m_ani;
                ns = si ? ((m_spd + 1 > SL - 1) ? SL - 1 : m_spd + 1)
                   : sd ? ((m_spd - 1 < 0) ? 0 : m_spd - 1) : m_spd;
                m_cfg = (na != m_ani) || (ns != m_spd);
                m_ani = na;
                m_spd = ns;
            end

            begin
                logic [3:0] ep;
                ep = {m_pulse[3], m_pulse[2], m_pulse[1], m_pulse[0]};
                checks++;
                if (btn_pulse !== ep || ani_sel !== 3'(m_ani) || speed_lvl !== 3'(m_spd)
                    || cfg_changed !== m_cfg) begin
                    errors++;
                    $display("FAIL cycle %0d: got pulse=%b ani=%0d spd=%0d cfg=%b, expected pulse=%b ani=%0d spd=%0d cfg=%b",
                             edge_cnt, btn_pulse, ani_sel, speed_lvl, cfg_changed,
                             ep, m_ani, m_spd, m_cfg);
                end
            end

            for (int b = 0; b < 4; b++) begin
                if (btn_pulse[b] === 1'b1) begin
                    pcnt[b]++;
                    last_edge[b] = edge_cnt;
                end
            end
            if (cfg_changed === 1'b1) cfg_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("check %-22s got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int start, p, c0;
        int ani_seq[5] = '{2, 3, 4, 5, 0};
        int up_seq[5]  = '{4, 5, 6, 7, 7};
        int dn_seq[8]  = '{6, 5, 4, 3, 2, 1, 0, 0};

        rst_n = 1'b0;
        ena   = 1'b1;
        btn   = 4'b0000;
        tick(2);
        rst_n = 1'b1;

        // Idle after reset
        tick(20);
        check("idle ani_sel", ani_sel, 0);
        check("idle speed_lvl", speed_lvl, 3);
        check("idle pulses", pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3], 0);

        // First increment and its latency
        start  = edge_cnt + 1;
        btn[0] = 1'b1;
        tick(20);
        check("inc_ani pulses", pcnt[0], 1);
        check("inc_ani latency", last_edge[0] - start, 6);
        check("inc_ani ani_sel", ani_sel, 1);
        check("inc_ani cfg_changed", cfg_cnt, 1);
        for (int i = 0; i < 5; i++) begin
            btn[0] = 1'b0; tick(10);
            btn[0] = 1'b1; tick(10);
            check("inc_ani wrap seq", ani_sel, ani_seq[i]);
        end
        btn[0] = 1'b0;
        tick(10);

        // Bouncing dec-anim never accepted, then a steady press wraps 0 -> 5
        p = pcnt[1];
        for (int i = 0; i < 10; i++) begin
            btn[1] = 1'b1; tick(3);
            btn[1] = 1'b0; tick(1);
        end
        check("bounce pulses", pcnt[1] - p, 0);
        check("bounce ani_sel", ani_sel, 0);
        btn[1] = 1'b1;
        tick(10);
        check("dec_ani pulses", pcnt[1] - p, 1);
        check("dec_ani wrap", ani_sel, 5);
        btn[1] = 1'b0;
        tick(10);

        // Speed saturation at both ends
        c0 = cfg_cnt;
        for (int i = 0; i < 5; i++) begin
            btn[2] = 1'b1; tick(10);
            btn[2] = 1'b0; tick(10);
            check("inc_spd seq", speed_lvl, up_seq[i]);
        end
        check("inc_spd pulses", pcnt[2], 5);
        check("inc_spd cfg_changed", cfg_cnt - c0, 4);
        for (int i = 0; i < 8; i++) begin
            btn[3] = 1'b1; tick(10);
            btn[3] = 1'b0; tick(10);
            check("dec_spd seq", speed_lvl, dn_seq[i]);
        end
        check("dec_spd pulses", pcnt[3], 8);

        // Simultaneous inc/dec animation cancels
        c0 = cfg_cnt;
        p  = pcnt[0];
        btn[1:0] = 2'b11;
        tick(10);
        check("cancel inc pulse", pcnt[0] - p, 1);
        check("cancel same edge", last_edge[0], last_edge[1]);
        check("cancel ani_sel", ani_sel, 5);
        check("cancel cfg_changed", cfg_cnt - c0, 0);
        btn[1:0] = 2'b00;
        tick(10);

        // Reset during PRESS_WAIT with the button still held afterwards
        btn[2] = 1'b1;
        tick(3);
        rst_n = 1'b0;
        tick(1);
        check("reset speed_lvl", speed_lvl, 3);
        check("reset ani_sel", ani_sel, 0);
        rst_n = 1'b1;
        start = edge_cnt + 1;
        p     = pcnt[2];
        tick(12);
        check("post-reset pulses", pcnt[2] - p, 1);
        check("post-reset latency", last_edge[2] - start, 6);
        check("post-reset speed_lvl", speed_lvl, 4);
        btn[2] = 1'b0;
        tick(10);

        // Enable low for a whole press, then dropped mid-count
        ena    = 1'b0;
        p      = pcnt[0];
        btn[0] = 1'b1;
        tick(15);
        check("ena-off pulses", pcnt[0] - p, 0);
        check("ena-off ani_sel", ani_sel, 0);
        btn[0] = 1'b0;
        tick(2);
        ena = 1'b1;
        tick(10);
        p      = pcnt[2];
        btn[2] = 1'b1;
        tick(4);
        ena = 1'b0;
        tick(3);
        btn[2] = 1'b0;
        ena    = 1'b1;
        tick(12);
        check("ena-drop pulses", pcnt[2] - p, 0);
        check("ena-drop speed_lvl", speed_lvl, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
